// File: rtl/game_pkg.sv
// Shared constants for the coin hit judge: frame FSM encodings, lane indices,
// default sizing and the saturating counter helpers.
package game_pkg;

    localparam int          LANES_DEFAULT     = 3;
    localparam logic [15:0] SCORE_MAX_DEFAULT = 16'd9999;
    localparam logic [15:0] DEBOUNCE_DEFAULT  = 16'd50000;
    localparam logic [7:0]  COMBO_MAX         = 8'd255;

    localparam logic [1:0]  LANE_LEFT   = 2'd0;
    localparam logic [1:0]  LANE_CENTER = 2'd1;
    localparam logic [1:0]  LANE_RIGHT  = 2'd2;

    typedef logic [1:0] frame_state_t;
    localparam frame_state_t ST_IDLE  = 2'd0;
    localparam frame_state_t ST_ACCUM = 2'd1;
    localparam frame_state_t ST_LATCH = 2'd2;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value, input logic [15:0] limit);
        logic [15:0] result;
        if (value >= limit) begin
            result = limit;
        end else begin
            result = value + 16'd1;
        end
        return result;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        logic [7:0] result;
        if (value >= COMBO_MAX) begin
            result = COMBO_MAX;
        end else begin
            result = value + 8'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/btn_conditioner.sv
// One player button: two-flop synchroniser, optional stability filter
// (COIN_JUDGE_DEBOUNCE_EN) and rising-edge press detection.
module btn_conditioner import game_pkg::*; #(
    parameter logic [15:0] DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press
);

    logic sync1_r;
    logic sync2_r;
    logic level_s;
    logic prev_r;

    // Bring the asynchronous button into the clock domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= btn;
            sync2_r <= sync1_r;
        end
    end

`ifdef COIN_JUDGE_DEBOUNCE_EN
    logic        stable_r;
    logic [15:0] cnt_r;

    // A new level is accepted only after it has held for DEBOUNCE_CYCLES cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_r <= 1'b0;
            cnt_r    <= 16'd0;
        end else if (sync2_r == stable_r) begin
            cnt_r <= 16'd0;
        end else if (cnt_r >= DEBOUNCE_CYCLES - 16'd1) begin
            stable_r <= sync2_r;
            cnt_r    <= 16'd0;
        end else begin
            cnt_r <= cnt_r + 16'd1;
        end
    end

    assign level_s = stable_r;
`else
    assign level_s = sync2_r;
`endif

    // Previous accepted level for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_r <= 1'b0;
        end else begin
            prev_r <= level_s;
        end
    end

    assign press = level_s & ~prev_r;

endmodule

// File: rtl/coin_hit_judge.sv
// Rhythm-game coin judge: per-frame hit accumulation, press serialisation and
// saturating score/combo. Build macro: COIN_JUDGE_DEBOUNCE_EN (button filter).
module coin_hit_judge import game_pkg::*; #(
    parameter int          LANES           = LANES_DEFAULT,
    parameter logic [15:0] DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter logic [15:0] SCORE_MAX       = SCORE_MAX_DEFAULT
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_v_sync,
    input  logic [LANES-1:0] i_sprite_hit,
    input  logic [LANES-1:0] i_btn,
    output logic [15:0]      o_score,
    output logic [7:0]       o_combo,
    output logic             o_judge_valid,
    output logic             o_judge_good,
    output logic [1:0]       o_judge_lane
);

    logic [LANES-1:0] press_s;
    logic             vs_prev_r;
    logic             vs_rise_s;
    frame_state_t     state_r;
    frame_state_t     state_next_s;
    logic             accept_s;
    logic [LANES-1:0] acc_r;
    logic [LANES-1:0] armed_r;
    logic [LANES-1:0] scored_r;
    logic [LANES-1:0] pend_r;
    logic [LANES-1:0] cand_s;
    logic [LANES-1:0] sel_onehot_s;
    logic [LANES-1:0] fall_s;
    logic [LANES-1:0] score_set_s;
    logic [1:0]       sel_lane_s;
    logic             sel_valid_s;
    logic             take_s;
    logic             good_s;
    logic [15:0]      score_r;
    logic [7:0]       combo_r;
    logic             judge_valid_r;
    logic             judge_good_r;
    logic [1:0]       judge_lane_r;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        btn_conditioner #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_cond (
            .clk  (i_clk),
            .rst_n(i_rst_n),
            .btn  (i_btn[l]),
            .press(press_s[l])
        );
    end

    // Frame boundary detection
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vs_prev_r <= 1'b0;
        end else begin
            vs_prev_r <= i_v_sync;
        end
    end

    assign vs_rise_s = i_v_sync & ~vs_prev_r;

    // Frame FSM next state
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (vs_rise_s) begin
                    state_next_s = ST_ACCUM;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (vs_rise_s) begin
                    state_next_s = ST_LATCH;
                end else begin
                    state_next_s = ST_ACCUM;
                end
            end
            ST_LATCH: state_next_s = ST_ACCUM;
            default:  state_next_s = ST_IDLE;
        endcase
    end

    // Frame FSM state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    assign accept_s = (state_r == ST_ACCUM) || (state_r == ST_LATCH);

    // Hit accumulation; armed_r is what the previous frame saw
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acc_r   <= '0;
            armed_r <= '0;
        end else if (vs_rise_s) begin
            armed_r <= acc_r;
            acc_r   <= '0;
        end else begin
            acc_r <= acc_r | i_sprite_hit;
        end
    end

    assign cand_s = pend_r | (press_s & {LANES{accept_s}});

    // Lowest candidate lane wins this cycle; the rest stay pending
    always_comb begin
        sel_valid_s  = 1'b0;
        sel_lane_s   = LANE_LEFT;
        sel_onehot_s = '0;
        take_s       = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            take_s          = cand_s[l] & ~sel_valid_s;
            sel_lane_s      = take_s ? 2'(l) : sel_lane_s;
            sel_onehot_s[l] = take_s;
            sel_valid_s     = sel_valid_s | take_s;
        end
    end

    // Judged against pre-transfer armed_r, so a press coinciding with v_sync sees the old frame
    assign good_s      = |(sel_onehot_s & armed_r & ~scored_r);
    assign fall_s      = vs_rise_s ? (armed_r & ~acc_r) : '0;
    assign score_set_s = good_s ? sel_onehot_s : '0;

    // Pending presses and per-coin scored flags; a coin leaving the zone re-enables scoring
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pend_r   <= '0;
            scored_r <= '0;
        end else begin
            pend_r   <= cand_s & ~sel_onehot_s;
            scored_r <= (scored_r | score_set_s) & ~fall_s;
        end
    end

    // Judgment outputs and saturating score/combo
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            score_r       <= 16'd0;
            combo_r       <= 8'd0;
            judge_valid_r <= 1'b0;
            judge_good_r  <= 1'b0;
            judge_lane_r  <= LANE_LEFT;
        end else begin
            judge_valid_r <= sel_valid_s;
            judge_good_r  <= sel_valid_s & good_s;
            judge_lane_r  <= sel_lane_s;
            if (sel_valid_s && good_s) begin
                score_r <= sat_inc16(score_r, SCORE_MAX);
                combo_r <= sat_inc8(combo_r);
            end else if (sel_valid_s) begin
                combo_r <= 8'd0;
            end else begin
                combo_r <= combo_r;
            end
        end
    end

    assign o_score       = score_r;
    assign o_combo       = combo_r;
    assign o_judge_valid = judge_valid_r;
    assign o_judge_good  = judge_good_r;
    assign o_judge_lane  = judge_lane_r;

endmodule

// File: tb/tb_coin_hit_judge.sv
// Self-checking bench for coin_hit_judge: scoreboard of expected judgments
// plus a table of frame/press steps and hand-written corner sequences.
module tb_coin_hit_judge;

    localparam logic [15:0] SAT = 16'd200;
`ifdef COIN_JUDGE_DEBOUNCE_EN
    localparam int DEB  = 8;
    localparam int HOLD = 14;
`else
    localparam int DEB  = 0;
    localparam int HOLD = 4;
`endif
    localparam int LAT = 3 + DEB;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_v_sync = 1'b0;
    logic [2:0]  i_sprite_hit = 3'b000;
    logic [2:0]  i_btn = 3'b000;
    logic [15:0] o_score;
    logic [7:0]  o_combo;
    logic        o_judge_valid;
    logic        o_judge_good;
    logic [1:0]  o_judge_lane;

    coin_hit_judge #(
        .LANES          (3),
        .DEBOUNCE_CYCLES(16'd8),
        .SCORE_MAX      (SAT)
    ) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_v_sync     (i_v_sync),
        .i_sprite_hit (i_sprite_hit),
        .i_btn        (i_btn),
        .o_score      (o_score),
        .o_combo      (o_combo),
        .o_judge_valid(o_judge_valid),
        .o_judge_good (o_judge_good),
        .o_judge_lane (o_judge_lane)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0]  lane;
        logic        good;
        logic [15:0] score;
        logic [7:0]  combo;
        int          at;
    } exp_t;

    typedef struct {
        logic [2:0] hits;
        logic [2:0] press;
        logic [2:0] good;
    } vec_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    vec_t        tbl[11];
    int          n_checks = 0;
    int          n_pass = 0;
    int          njudge = 0;
    int          j0;
    int          t0;
    logic [15:0] m_score = 16'd0;
    logic [7:0]  m_combo = 8'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    // Scoreboard consumer: every judgment must match the oldest expectation
    always @(negedge i_clk) begin
        if (i_rst_n === 1'b1 && o_judge_valid === 1'b1) begin
            njudge++;
            if (sbq.size() == 0) begin
                chk("unexpected_judgment", 32'd1, 32'd0);
            end else begin
                mon_e = sbq.pop_front();
                chk("judge_lane", 32'(o_judge_lane), 32'(mon_e.lane));
                chk("judge_good", 32'(o_judge_good), 32'(mon_e.good));
                chk("score", 32'(o_score), 32'(mon_e.score));
                chk("combo", 32'(o_combo), 32'(mon_e.combo));
                chk("judge_cycle", 32'(cyc), 32'(mon_e.at));
            end
        end
    end

    task automatic expect_press(input logic [2:0] mask, input logic [2:0] good, input int t);
        int idx = 0;
        for (int l = 0; l < 3; l++) begin
            if (mask[l]) begin
                if (good[l]) begin
                    m_score = (m_score >= SAT) ? SAT : m_score + 16'd1;
                    m_combo = (m_combo == 8'd255) ? 8'd255 : m_combo + 8'd1;
                end else begin
                    m_combo = 8'd0;
                end
                sbq.push_back('{lane: 2'(l), good: good[l], score: m_score, combo: m_combo, at: t + LAT + idx});
                idx++;
            end
        end
    endtask

    task automatic drain();
        int k = 0;
        while (sbq.size() != 0 && k < 60) begin
            cycles(1);
            k++;
        end
        chk("drain_queue", 32'(sbq.size()), 32'd0);
    endtask

    task automatic frame(input logic [2:0] hits);
        i_sprite_hit = hits;
        cycles(10);
        i_sprite_hit = 3'b000;
        cycles(2);
        i_v_sync = 1'b1;
        cycles(2);
        i_v_sync = 1'b0;
        cycles(2);
    endtask

    task automatic press(input logic [2:0] mask, input logic [2:0] good, input int hold);
        if (mask != 3'b000) begin
            expect_press(mask, good, cyc);
            i_btn = mask;
            cycles(hold);
            i_btn = 3'b000;
            cycles(hold);
            drain();
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{hits: 3'b000, press: 3'b000, good: 3'b000};
        tbl[1]  = '{hits: 3'b111, press: 3'b111, good: 3'b111};
        tbl[2]  = '{hits: 3'b000, press: 3'b000, good: 3'b000};
        tbl[3]  = '{hits: 3'b100, press: 3'b100, good: 3'b100};
        tbl[4]  = '{hits: 3'b000, press: 3'b001, good: 3'b000};
        tbl[5]  = '{hits: 3'b100, press: 3'b100, good: 3'b100};
        tbl[6]  = '{hits: 3'b100, press: 3'b100, good: 3'b000};
        tbl[7]  = '{hits: 3'b000, press: 3'b000, good: 3'b000};
        tbl[8]  = '{hits: 3'b011, press: 3'b111, good: 3'b011};
        tbl[9]  = '{hits: 3'b000, press: 3'b010, good: 3'b000};
        tbl[10] = '{hits: 3'b111, press: 3'b111, good: 3'b111};

        cycles(3);
        chk("rst_score", 32'(o_score), 32'd0);
        chk("rst_combo", 32'(o_combo), 32'd0);
        chk("rst_valid", 32'(o_judge_valid), 32'd0);
        chk("rst_good", 32'(o_judge_good), 32'd0);
        chk("rst_lane", 32'(o_judge_lane), 32'd0);
        i_rst_n = 1'b1;
        cycles(2);

        // Presses before the first frame boundary are discarded
        j0 = njudge;
        i_btn = 3'b001;
        cycles(HOLD);
        i_btn = 3'b000;
        cycles(HOLD + 10);
        chk("idle_drop", 32'(njudge - j0), 32'd0);

        // Lane 1 coin seen for 10 pixels, pressed in the next frame
        frame(3'b000);
        frame(3'b010);
        press(3'b010, 3'b010, HOLD);

        for (int i = 0; i < 11; i++) begin
            frame(tbl[i].hits);
            press(tbl[i].press, tbl[i].good, HOLD);
        end

        // Press edge coinciding with the v_sync rise uses the old armed value
        frame(3'b000);
        frame(3'b001);
        cycles(4);
        t0 = cyc;
        expect_press(3'b001, 3'b001, t0);
        i_btn = 3'b001;
        cycles(LAT - 1);
        i_v_sync = 1'b1;
        cycles(2);
        i_v_sync = 1'b0;
        cycles(HOLD);
        i_btn = 3'b000;
        cycles(HOLD);
        drain();
        press(3'b001, 3'b000, HOLD);

`ifndef COIN_JUDGE_DEBOUNCE_EN
        // Second lane-2 edge while lane 2 is still pending is dropped
        frame(3'b000);
        frame(3'b111);
        j0 = njudge;
        t0 = cyc;
        expect_press(3'b111, 3'b111, t0);
        i_btn = 3'b111;
        cycles(1);
        i_btn = 3'b011;
        cycles(1);
        i_btn = 3'b111;
        cycles(4);
        i_btn = 3'b000;
        cycles(4);
        drain();
        chk("pending_drop", 32'(njudge - j0), 32'd3);
`else
        // Short glitch is filtered, a long press is judged once
        frame(3'b001);
        j0 = njudge;
        i_btn = 3'b001;
        cycles(5);
        i_btn = 3'b000;
        cycles(20);
        chk("glitch_filtered", 32'(njudge - j0), 32'd0);
        press(3'b001, 3'b001, 20);
        chk("long_press_once", 32'(njudge - j0), 32'd1);
`endif

        // Reset mid-serialisation loses lanes 1 and 2
        frame(3'b000);
        frame(3'b111);
        j0 = njudge;
        t0 = cyc;
        expect_press(3'b001, 3'b001, t0);
        i_btn = 3'b111;
        cycles(LAT);
        #2;
        i_rst_n = 1'b0;
        i_btn = 3'b000;
        cycles(3);
        chk("midrst_score", 32'(o_score), 32'd0);
        chk("midrst_combo", 32'(o_combo), 32'd0);
        i_rst_n = 1'b1;
        m_score = 16'd0;
        m_combo = 8'd0;
        cycles(HOLD + 10);
        chk("midrst_judgments", 32'(njudge - j0), 32'd1);
        chk("midrst_queue", 32'(sbq.size()), 32'd0);

        // Drive score past SCORE_MAX and combo past 255
        frame(3'b000);
        for (int i = 0; i < 90; i++) begin
            frame(3'b111);
            press(3'b111, 3'b111, HOLD);
            frame(3'b000);
        end
        chk("sat_score", 32'(o_score), 32'(SAT));
        chk("sat_combo", 32'(o_combo), 32'd255);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/coin_hit_judge.md
COIN_HIT_JUDGE -- requirements
Module: coin_hit_judge

Interface
REQ-001 SHALL have parameter LANES, default 3, meaning number of coin lanes (0=left, 1=center, 2=right).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 16'd50000, meaning cycles a button must be stable before it is accepted.
REQ-003 SHALL have parameter SCORE_MAX, default 16'd9999, meaning the score saturation value.
REQ-004 SHALL have port i_clk, input, 1, the pixel clock; the only clock.
REQ-005 SHALL have port i_rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port i_v_sync, input, 1, vertical sync in the i_clk domain; a rising edge marks a frame boundary.
REQ-007 SHALL have port i_sprite_hit, input, LANES, per-lane coin sprite hit-zone pixel flag, valid each i_clk.
REQ-008 SHALL have port i_btn, input, LANES, asynchronous raw player buttons, active-high.
REQ-009 SHALL have port o_score, output, 16, the saturating score.
REQ-010 SHALL have port o_combo, output, 8, consecutive good judgments, saturating at 255.
REQ-011 SHALL have port o_judge_valid, output, 1, a one-cycle pulse per judgment.
REQ-012 SHALL have port o_judge_good, output, 1, the judgment result, valid with o_judge_valid.
REQ-013 SHALL have port o_judge_lane, output, 2, the lane of the judgment, valid with o_judge_valid.

Function
REQ-014 SHALL synchronise i_btn through 2 flip-flops per lane, then detect a rising edge (press event).
REQ-015 SHALL, per lane, OR i_sprite_hit across the current frame into acc[lane], and transfer acc into armed_frame[lane] on each i_v_sync rising edge, clearing acc in the same cycle.
REQ-016 SHALL implement a frame FSM: IDLE -> ACCUM on the first i_v_sync rising edge after reset; ACCUM -> LATCH on an i_v_sync rising edge; LATCH -> ACCUM after 1 cycle; only ACCUM and LATCH accept presses.
REQ-017 SHALL keep a per-lane scored[lane] flag: set on a good judgment, cleared when armed_frame[lane] goes 1->0 (coin left the zone).
REQ-018 SHALL judge a press on a lane as good iff armed_frame[lane]=1 and scored[lane]=0; otherwise it is a miss.
REQ-019 SHALL, on a good judgment, increment o_score by 1 (saturating at SCORE_MAX) and o_combo by 1 (saturating at 255), and on a miss clear o_combo to 0 with o_score unchanged.
REQ-020 SHALL assert o_judge_valid exactly 1 cycle after the accepted press edge, with o_score/o_combo updated in that same cycle.
REQ-021 SHALL, on simultaneous presses in several lanes, judge them serially in ascending lane order, one per cycle, with pending presses held in a per-lane pending bit.
REQ-022 SHALL, for a second press in a lane whose pending bit is still set, drop the second press with no judgment.
REQ-023 SHALL, when a press and an i_v_sync rising edge coincide, judge the press against the armed_frame value before the transfer.
REQ-024 SHALL discard presses in IDLE.

Reset
REQ-025 SHALL, on i_rst_n low, asynchronously clear o_score=0, o_combo=0, o_judge_valid=0, o_judge_good=0, o_judge_lane=0, acc, armed_frame, scored, pending and the synchronisers, and set the FSM to IDLE.
REQ-026 SHALL, on reset asserted mid-frame or mid-serialisation, lose all pending presses with no judgment emitted.

Configuration
REQ-027 SHALL, with macro COIN_JUDGE_DEBOUNCE_EN defined, require a synchronised button to stay stable for DEBOUNCE_CYCLES cycles (per-lane counter) before edge detection; without it, edges are taken directly from the synchroniser output.

Structure
REQ-028 SHALL place the FSM state enum, LANES default, SCORE_MAX default and lane index constants in shared package game_pkg.
REQ-029 SHALL implement per-lane sync/debounce/edge logic as sub-module btn_conditioner, instantiated LANES times.

Verification
REQ-030 SHALL cover: lane 1 hit flag for 10 pixels in frame N, press in frame N+1 -> o_judge_valid=1, good=1, lane=1, score 0->1, combo 0->1.
REQ-031 SHALL cover: press lane 0 with no hit in the previous frame -> good=0, combo 5->0, score unchanged.
REQ-032 SHALL cover: two presses on the same coin in lane 2 -> first good (score+1), second miss (combo=0).
REQ-033 SHALL cover: all 3 lanes pressed in the same cycle, all armed -> judgments on 3 consecutive cycles, lanes 0,1,2, score +3.
REQ-034 SHALL cover: score at 9999 with a good press -> score stays 9999 and combo increments; combo at 255 with a good press -> combo stays 255.
REQ-035 SHALL cover: COIN_JUDGE_DEBOUNCE_EN with DEBOUNCE_CYCLES=8 and a 5-cycle glitch -> no judgment; a 20-cycle press -> 1 judgment.
